ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the 2-read/1-write solver RAM (N-bit words, M entries, K-bit addresses) between NREQ solver-stage requesters.
- After reset, sweeps the RAM to zero. Then, every cycle, grants up to one write and up to two reads, using round-robin arbitration.
- Sits between the ODE datapath stages and the RAM. Drives the RAM's WE, address and write-data pins directly, and returns registered read data to each requester.

Parameters:
- N, 16, data word width
- M, 6000, RAM depth (number of entries)
- K, 13, address width; requires 2^K >= M
- NREQ, 4, number of requesters; at least 2

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request, held until granted
- we  in  NREQ  per-requester op: 1 = write, 0 = read
- addr  in  NREQ*K  per-requester address, lane i = bits [i*K +: K]
- wdata  in  NREQ*N  per-requester write data
- gnt  out  NREQ  one-hot-per-port grant, combinational, same cycle as the access
- rvalid  out  NREQ  read data valid, registered
- rdata  out  NREQ*N  per-requester read data, registered, held until next rvalid on that lane
- busy  out  1  high during the INIT clear sweep
- WE  out  1  RAM write enable
- addressPortOne  out  K  RAM read port 1 address
- addressPortTwo  out  K  RAM read port 2 address
- addressWritePort  out  K  RAM write address
- writePortData  out  N  RAM write data
- readPortOneData  in  N  RAM read port 1 data (asynchronous read)
- readPortTwoData  in  N  RAM read port 2 data (asynchronous read)

Behaviour:
- Reset (Rst_n=0 sampled at an edge):
  - state <= INIT, clear counter <= 0, wptr <= 0, rptr <= 0, rvalid <= 0, rdata <= 0.
  - While Rst_n=0: gnt=0, WE=0, addresses=0, writePortData=0.
- INIT state:
  - busy=1, gnt=0.
  - WE=1, addressWritePort=counter, writePortData=0; counter increments each cycle.
  - After writing M-1, go to RUN. Sweep length is exactly M cycles.
- RUN state:
  - busy=0.
  - Write arbitration: among lanes with req&we, search round-robin from wptr. The winner w gets gnt[w]=1, WE=1, addressWritePort=addr[w], writePortData=wdata[w]. Then wptr <= (w+1) mod NREQ.
  - No write candidate: WE=0 and wptr holds.
  - Read arbitration: among lanes with req&~we, search round-robin from rptr.
    - The first winner r1 goes on port one and the second winner r2 on port two; both get gnt=1.
    - rptr <= (last granted read lane + 1) mod NREQ.
    - With only one candidate, port two is unused: address 0, no grant.
  - Read latency: read data is sampled at the grant-cycle edge into rdata lane r; rvalid[r]=1 the following cycle for exactly one cycle.
  - A requester may re-request immediately after gnt. Back-to-back reads give consecutive rvalid pulses.
- Handshake:
  - A transfer occurs when req[i] & gnt[i] are both high at an edge.
  - The requester must keep we/addr/wdata stable while req is high and gnt is low.
  - gnt is never asserted without req.
- Same-address read and write in one cycle: returned data is the pre-write RAM contents, unless the optional feature below is enabled.
- Addresses >= M are passed through unchecked.
- Reset mid-sweep or mid-RUN: pending grants are dropped, rvalid is cleared, and the sweep restarts at address 0.

Optional Feature:
- Macro: RD_WR_FORWARD_EN.
- Defined: when a granted read address equals the granted write address in the same cycle, the captured rdata is the write data (new value).
- Undefined: the captured rdata is the RAM's old value. No comparators are instantiated.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {INIT, RUN}
  - lane index width function (clog2 of NREQ)
  - lane slice helper constants
- One natural sub-module: rr_pick.
  - Inputs: NREQ-bit candidate mask and start pointer.
  - Outputs: valid flag and winner index.
  - Instantiated once for the write port.
  - For reads: instantiated once, then again with the first winner masked off.

Test Plan:
- Reset, then idle with NREQ=4, M=8: busy=1 for exactly 8 cycles with WE=1 at addresses 0..7, writePortData=0. Then busy=0, gnt=0, WE=0.
- Lane 0 writes 10 to address 3; the next cycle lane 1 reads address 3: gnt[0] in cycle 1, gnt[1] in cycle 2, rvalid[1] in cycle 3 with rdata lane 1 = 10.
- All four lanes request reads of addresses 0..3 (preloaded with 20..23), rptr=0:
  - Cycle 1 grants lanes 0 and 1; cycle 2 grants lanes 2 and 3.
  - rvalid pulses return 20..23 on the matching lanes, one cycle after each grant.
- Lanes 0, 1 and 2 continuously request writes: grants rotate 0,1,2,0,1,2; WE stays 1 every cycle.
- Same-cycle write of 55 and read of address 5 (old value 7): rdata=7 without RD_WR_FORWARD_EN, 55 with it.
- Rst_n low for one edge mid-RUN with reads outstanding: the next cycle has rvalid=0 and busy=1; the sweep restarts at address 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and lane-index helpers for the solver RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arbState_e;

  // Width of a lane index for nReq requesters (never narrower than one bit).
  function automatic int unsigned laneW(input int unsigned nReq);
    return (nReq <= 1) ? 1 : $clog2(nReq);
  endfunction

  // Round-robin successor of a lane index.
  function automatic int unsigned laneNext(input int unsigned idx, input int unsigned nReq);
    return (idx + 1 >= nReq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned LW = laneW(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [LW-1:0]   start,
  output logic            valid,
  output logic [LW-1:0]   idx
);

  always_comb begin
    int unsigned bestOff;
    int unsigned off;
    valid   = 1'b0;
    idx     = '0;
    bestOff = NREQ;
    off     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (mask[k]) begin
        off = (k + NREQ - 32'(start)) % NREQ;
        if (off < bestOff) begin
          bestOff = off;
          idx     = LW'(k);
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a 2-read/1-write RAM between NREQ requesters after a zeroing sweep.
// Define RD_WR_FORWARD_EN to return write data on a same-cycle address match.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned M    = 6000,
  parameter int unsigned K    = 13,
  parameter int unsigned NREQ = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*K-1:0] addr,
  input  logic [NREQ*N-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*N-1:0] rdata,
  output logic              busy,
  output logic              WE,
  output logic [K-1:0]      addressPortOne,
  output logic [K-1:0]      addressPortTwo,
  output logic [K-1:0]      addressWritePort,
  output logic [N-1:0]      writePortData,
  input  logic [N-1:0]      readPortOneData,
  input  logic [N-1:0]      readPortTwoData
);

  localparam int unsigned LW     = laneW(NREQ);
  localparam logic [0:0]  S_INIT = 1'(INIT);
  localparam logic [0:0]  S_RUN  = 1'(RUN);

  logic [0:0]      state, stateNext;
  logic [K-1:0]    cnt, cntNext;
  logic [LW-1:0]   wptr, wptrNext, rptr, rptrNext;
  logic [NREQ-1:0] wrMask, rdMask, rdMask2;
  logic            wrValid, rd1Valid, rd2Valid;
  logic [LW-1:0]   wrIdx, rd1Idx, rd2Idx;
  logic            wrGo, rd1Go, rd2Go;
  logic [N-1:0]    rd1Data, rd2Data;

  assign wrMask = req & we;
  assign rdMask = req & ~we;

  // Second read search excludes the first read winner.
  always_comb begin
    rdMask2 = rdMask;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (rd1Valid && rd1Idx == LW'(k)) rdMask2[k] = 1'b0;
    end
  end

  rr_pick #(.NREQ(NREQ)) uWrPick  (.mask(wrMask),  .start(wptr), .valid(wrValid),  .idx(wrIdx));
  rr_pick #(.NREQ(NREQ)) uRd1Pick (.mask(rdMask),  .start(rptr), .valid(rd1Valid), .idx(rd1Idx));
  rr_pick #(.NREQ(NREQ)) uRd2Pick (.mask(rdMask2), .start(rptr), .valid(rd2Valid), .idx(rd2Idx));

  // Next state, grants and RAM pin drive; everything forced idle while in reset.
  always_comb begin
    stateNext        = state;
    cntNext          = cnt;
    wptrNext         = wptr;
    rptrNext         = rptr;
    gnt              = '0;
    WE               = 1'b0;
    addressWritePort = '0;
    writePortData    = '0;
    addressPortOne   = '0;
    addressPortTwo   = '0;
    wrGo             = 1'b0;
    rd1Go            = 1'b0;
    rd2Go            = 1'b0;
    busy             = (state == S_INIT);
    if (Rst_n) begin
      case (state)
        S_INIT: begin
          WE               = 1'b1;
          addressWritePort = cnt;
          if (cnt == K'(M - 1)) begin
            stateNext = S_RUN;
            cntNext   = '0;
          end else begin
            cntNext = cnt + K'(1);
          end
        end
        default: begin
          wrGo  = wrValid;
          rd1Go = rd1Valid;
          rd2Go = rd1Valid && rd2Valid;
          WE    = wrGo;
          for (int unsigned k = 0; k < NREQ; k++) begin
            if (wrGo && wrIdx == LW'(k)) begin
              gnt[k]           = 1'b1;
              addressWritePort = addr[k*K +: K];
              writePortData    = wdata[k*N +: N];
            end
            if (rd1Go && rd1Idx == LW'(k)) begin
              gnt[k]         = 1'b1;
              addressPortOne = addr[k*K +: K];
            end
            if (rd2Go && rd2Idx == LW'(k)) begin
              gnt[k]         = 1'b1;
              addressPortTwo = addr[k*K +: K];
            end
          end
          if (wrGo) wptrNext = LW'(laneNext(32'(wrIdx), NREQ));
          if (rd2Go)      rptrNext = LW'(laneNext(32'(rd2Idx), NREQ));
          else if (rd1Go) rptrNext = LW'(laneNext(32'(rd1Idx), NREQ));
        end
      endcase
    end
  end

  // Captured read data; optionally bypass the RAM when the write hits the same word.
  always_comb begin
    rd1Data = readPortOneData;
    rd2Data = readPortTwoData;
`ifdef RD_WR_FORWARD_EN
    if (wrGo && addressPortOne == addressWritePort) rd1Data = writePortData;
    if (wrGo && addressPortTwo == addressWritePort) rd2Data = writePortData;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      wptr  <= wptrNext;
      rptr  <= rptrNext;
    end
  end

  // Read return: one-cycle rvalid pulse, rdata held until the lane's next read.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        rvalid[k] <= (rd1Go && rd1Idx == LW'(k)) || (rd2Go && rd2Idx == LW'(k));
        if (rd1Go && rd1Idx == LW'(k)) rdata[k*N +: N] <= rd1Data;
        if (rd2Go && rd2Idx == LW'(k)) rdata[k*N +: N] <= rd2Data;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with an attached behavioural RAM.
module tb_ram_port_arbiter;

  localparam int unsigned N    = 16;
  localparam int unsigned M    = 8;
  localparam int unsigned K    = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned D    = 1 << K;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NREQ-1:0]   req, we, gnt, rvalid;
  logic [NREQ*K-1:0] addr;
  logic [NREQ*N-1:0] wdata, rdata;
  logic              busy, WE;
  logic [K-1:0]      addressPortOne, addressPortTwo, addressWritePort;
  logic [N-1:0]      writePortData, readPortOneData, readPortTwoData;
  logic              preset;

  logic [N-1:0] ram [0:D-1];
  logic [N-1:0] refMem [0:D-1];
  logic [N-1:0] expQ [NREQ][$];
  int nCmp = 0;
  int nBad = 0;

  ram_port_arbiter #(.N(N), .M(M), .K(K), .NREQ(NREQ)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .WE(WE),
    .addressPortOne(addressPortOne), .addressPortTwo(addressPortTwo),
    .addressWritePort(addressWritePort), .writePortData(writePortData),
    .readPortOneData(readPortOneData), .readPortTwoData(readPortTwoData)
  );

  always #5 Clk = ~Clk;

  function automatic logic [N-1:0] presetVal(input int i);
    return N'(i * 257 + 5);
  endfunction

  // Behavioural 2R/1W RAM with asynchronous reads.
  always @(posedge Clk) begin
    if (preset) begin
      for (int i = 0; i < D; i++) ram[i] <= presetVal(i);
    end else if (WE) begin
      ram[addressWritePort] <= writePortData;
    end
  end
  assign readPortOneData = ram[addressPortOne];
  assign readPortTwoData = ram[addressPortTwo];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int laneAddr(input int l);
    return int'(addr[l*K +: K]);
  endfunction

  function automatic logic [N-1:0] laneData(input int l);
    return wdata[l*N +: N];
  endfunction

  // Reference model: sweep, round-robin grants and read data from the spec rules.
  initial begin
    int initCnt, wp, rp, wl, r1, r2, a;
    logic [NREQ-1:0] eg;
    logic [N-1:0] d;
    for (int i = 0; i < D; i++) refMem[i] = presetVal(i);
    initCnt = 0; wp = 0; rp = 0;
    forever begin
      @(negedge Clk); #1;
      if (!Rst_n) begin
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_we", 32'(WE), 0);
        chk("rst_waddr", 32'(addressWritePort), 0);
        chk("rst_wdata", 32'(writePortData), 0);
        initCnt = 0; wp = 0; rp = 0;
        for (int i = 0; i < NREQ; i++) expQ[i].delete();
      end else if (initCnt < M) begin
        if (initCnt == 0) chk("init_rvalid", 32'(rvalid), 0);
        chk("init_busy", 32'(busy), 1);
        chk("init_we", 32'(WE), 1);
        chk("init_waddr", 32'(addressWritePort), 32'(initCnt));
        chk("init_wdata", 32'(writePortData), 0);
        chk("init_gnt", 32'(gnt), 0);
        refMem[initCnt] = '0;
        initCnt++;
      end else begin
        wl = -1; r1 = -1; r2 = -1; eg = '0;
        for (int o = 0; o < NREQ; o++) begin
          int l;
          l = (wp + o) % NREQ;
          if (wl < 0 && req[l] && we[l]) wl = l;
        end
        for (int o = 0; o < NREQ; o++) begin
          int l;
          l = (rp + o) % NREQ;
          if (req[l] && !we[l]) begin
            if (r1 < 0) r1 = l;
            else if (r2 < 0) r2 = l;
          end
        end
        if (wl >= 0) eg[wl] = 1'b1;
        if (r1 >= 0) eg[r1] = 1'b1;
        if (r2 >= 0) eg[r2] = 1'b1;
        chk("run_busy", 32'(busy), 0);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("we_pin", 32'(WE), (wl >= 0) ? 1 : 0);
        chk("waddr", 32'(addressWritePort), (wl >= 0) ? 32'(laneAddr(wl)) : 0);
        chk("wdata_pin", 32'(writePortData), (wl >= 0) ? 32'(laneData(wl)) : 0);
        chk("raddr1", 32'(addressPortOne), (r1 >= 0) ? 32'(laneAddr(r1)) : 0);
        chk("raddr2", 32'(addressPortTwo), (r2 >= 0) ? 32'(laneAddr(r2)) : 0);
        for (int j = 0; j < 2; j++) begin
          int r;
          r = (j == 0) ? r1 : r2;
          if (r >= 0) begin
            a = laneAddr(r);
            d = refMem[a];
`ifdef RD_WR_FORWARD_EN
            if (wl >= 0 && laneAddr(wl) == a) d = laneData(wl);
`endif
            expQ[r].push_back(d);
          end
        end
        if (wl >= 0) begin
          refMem[laneAddr(wl)] = laneData(wl);
          wp = (wl + 1) % NREQ;
        end
        if (r2 >= 0) rp = (r2 + 1) % NREQ;
        else if (r1 >= 0) rp = (r1 + 1) % NREQ;
      end
    end
  end

  // Monitor: every rvalid pulse must match the oldest expected read on that lane.
  always @(negedge Clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rvalid[i]) begin
        if (expQ[i].size() == 0) begin
          nCmp++; nBad++;
          $display("FAIL unexpected_rvalid lane %0d at %0t: got rdata %0h expected no response",
                   i, $time, rdata[i*N +: N]);
        end else begin
          logic [N-1:0] e;
          e = expQ[i].pop_front();
          chk($sformatf("rdata_lane%0d", i), 32'(rdata[i*N +: N]), 32'(e));
        end
      end
    end
  end

  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge Clk);
    g = gnt;
    @(posedge Clk); #1;
    req = req & ~g;
  endtask

  task automatic issue(input int l, input logic w, input int a, input logic [N-1:0] d);
    req[l] = 1'b1;
    we[l]  = w;
    addr[l*K +: K]  = K'(a);
    wdata[l*N +: N] = d;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (req != '0 && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout_req", 32'(req), 0);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; preset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    @(posedge Clk); #1;
    preset = 1'b0;
    step(); step();
    Rst_n = 1'b1;
    repeat (M) step();
    step(); step();

    // write then read back the same word on different lanes
    issue(0, 1'b1, 3, 16'd10);
    step();
    issue(1, 1'b0, 3, '0);
    waitIdle();

    // preload 20..23 then four simultaneous reads
    for (int l = 0; l < 4; l++) issue(l, 1'b1, l, N'(20 + l));
    waitIdle();
    for (int l = 0; l < 4; l++) issue(l, 1'b0, l, '0);
    waitIdle();

    // three lanes streaming writes
    repeat (6) begin
      for (int l = 0; l < 3; l++) if (!req[l]) issue(l, 1'b1, 4 + l, N'(100 + l));
      step();
    end
    waitIdle();

    // same-cycle write and read of one address
    issue(2, 1'b1, 5, 16'd7);
    waitIdle();
    issue(0, 1'b1, 5, 16'd55);
    issue(1, 1'b0, 5, '0);
    waitIdle();

    // random traffic with a reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        Rst_n = 1'b0;
        req = '0;
        step();
        Rst_n = 1'b1;
      end else begin
        for (int l = 0; l < NREQ; l++) begin
          if (!req[l] && $urandom_range(1, 0) == 1)
            issue(l, 1'($urandom_range(1, 0)), int'($urandom_range(D - 1, 0)), N'($urandom));
        end
        step();
      end
    end
    waitIdle();
    repeat (3) step();
    for (int i = 0; i < NREQ; i++) chk($sformatf("drain_lane%0d", i), 32'(expQ[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
